// File: rtl/fish_motion_ctrl.sv
// fish_motion_ctrl
// Per-fish motion generator. Turns a base tick (clk divided by TICK_DIV) into one-cycle
// horizontal/vertical step pulses with direction for a single fish sprite. It supports:
//   - a per-fish speed (one step every movetype+1 ticks),
//   - zig-zag depth bands (vertical direction follows bit BAND_SH of h),
//   - a caught mode (rise one step per tick),
//   - exit detection once h passes H_MAX.
//
// Optional feature macro: LFSR_JITTER_EN
//   When defined, an 8-bit LFSR randomly flips the band direction while swimming.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous reset, active-low
//   h         current fish horizontal position
//   way       0 left, 1 right, 2 caught, 3 hover (vertical only)
//   appear    1 = fish exists
//   movetype  speed: one step every movetype+1 base ticks
//   hm        horizontal step pulse (1 cycle)
//   hdir      horizontal direction, 0 left / 1 right, valid with hm
//   vm        vertical step pulse (1 cycle)
//   up        vertical direction level, 1 up / 0 down, updated only with vm
//   gone      1-cycle pulse on entering EXIT
//   state     IDLE=0 SWIM=1 CAUGHT=2 EXIT=3
module fish_motion_ctrl #(
    parameter int H_W      = 10,
    parameter int CNT_W    = 24,
    parameter int TICK_DIV = 3000000,
    parameter int BAND_SH  = 6,
    parameter int H_MAX    = 720
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [H_W-1:0] h,
    input  logic [1:0]     way,
    input  logic           appear,
    input  logic [2:0]     movetype,
    output logic           hm,
    output logic           hdir,
    output logic           vm,
    output logic           up,
    output logic           gone,
    output logic [1:0]     state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWIM   = 2'd1,
        CAUGHT = 2'd2,
        EXIT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [H_W-1:0]   H_LIMIT  = H_W'(H_MAX);

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sc;
    logic             counting;
    logic             tick;
    logic             step;
    logic             off_screen;
    logic             swim_up;

    // The prescaler only runs while the fish is actively moving (SWIM or CAUGHT).
    assign counting   = (cur_state == SWIM) || (cur_state == CAUGHT);
    assign tick       = counting && (cnt == CNT_LAST);
    // ">=" rather than "==" so that lowering movetype mid-count steps on the next tick
    // instead of wrapping sc all the way around through 7.
    assign step       = tick && (cur_state == SWIM) && (sc >= movetype);
    assign off_screen = (h > H_LIMIT);
    assign state      = cur_state;

`ifdef LFSR_JITTER_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, advanced once per base tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else if (tick) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Even band swims up, odd band down, occasionally flipped by the LFSR.
    assign swim_up = ~h[BAND_SH] ^ ((lfsr[2:1] == 2'b00) & lfsr[0]);
`else
    // Even band swims up, odd band down.
    assign swim_up = ~h[BAND_SH];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic; within each state, disappearance beats capture beats exit.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (appear && (way == 2'd2)) next_state = CAUGHT;
                else if (appear)             next_state = SWIM;
            end
            SWIM: begin
                if (!appear)            next_state = IDLE;
                else if (way == 2'd2)   next_state = CAUGHT;
                else if (off_screen)    next_state = EXIT;
            end
            CAUGHT: begin
                if (!appear)            next_state = IDLE;
                else if (way != 2'd2)   next_state = SWIM;
            end
            EXIT: begin
                if (!appear)            next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Prescaler and step divider. sc is held in CAUGHT so that swimming resumes
    // mid-count when the fish is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sc  <= '0;
        end else if (!counting) begin
            cnt <= '0;
            sc  <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick && (cur_state == SWIM)) begin
                sc <= (sc >= movetype) ? 3'd0 : sc + 3'd1;
            end
        end
    end

    // Registered outputs. The pulse decision uses the current (old) state, so a step
    // that lands on a state change is still emitted as that state would have.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hm   <= 1'b0;
            hdir <= 1'b0;
            vm   <= 1'b0;
            up   <= 1'b0;
            gone <= 1'b0;
        end else begin
            hm   <= 1'b0;
            vm   <= 1'b0;
            gone <= (cur_state != EXIT) && (next_state == EXIT);
            if (step) begin
                vm <= 1'b1;
                up <= swim_up;
                if (!way[1]) begin
                    hm   <= 1'b1;
                    hdir <= way[0];
                end
            end else if (tick && (cur_state == CAUGHT)) begin
                vm <= 1'b1;
                up <= 1'b1;
            end
        end
    end

endmodule
